// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game pipeline: collision/life FSM states, default
// tuning values, and the transparency colour used by the sprite renderers.
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    ST_PLAY    = 2'd0,
    ST_BOOM    = 2'd1,
    ST_RESPAWN = 2'd2,
    ST_OVER    = 2'd3
  } judge_state_t;

  localparam int LIVES_INIT_DEF  = 3;
  localparam int MIN_OVERLAP_DEF = 4;
  localparam int BOOM_FRAMES_DEF = 120;
  localparam int INV_FRAMES_DEF  = 90;

  // Sprite ROM pixels of this colour are treated as see-through by the renderers.
  localparam logic [11:0] COLOR_TRANSPARENT = 12'hFFF;

endpackage

// File: rtl/collision_judge_if.sv
// -----------------------------------------------------------------------------
// collision_judge_if
// Bundles the per-pixel renderer status, frame timing and game-control inputs
// of the collision judge together with its status outputs.
//   master : game/renderer side (drives pixel enables, frame_end, restart)
//   slave  : collision_judge (drives boom, hit_pulse, lives, invincible,
//            game_over)
// -----------------------------------------------------------------------------
interface collision_judge_if #(
  parameter int LIVES_W = 2
);
  logic               video_on;
  logic               frame_end;
  logic               plane_en;
  logic               enemy_en;
  logic               ebullet_en;
  logic               myplane_exist;
  logic               restart;
  logic               boom;
  logic               hit_pulse;
  logic [LIVES_W-1:0] lives;
  logic               invincible;
  logic               game_over;

  modport master (
    output video_on, frame_end, plane_en, enemy_en, ebullet_en,
           myplane_exist, restart,
    input  boom, hit_pulse, lives, invincible, game_over
  );

  modport slave (
    input  video_on, frame_end, plane_en, enemy_en, ebullet_en,
           myplane_exist, restart,
    output boom, hit_pulse, lives, invincible, game_over
  );
endinterface

// File: rtl/frame_timer.sv
// -----------------------------------------------------------------------------
// frame_timer
// Loadable down-counter stepped once per frame.
//   clk, rst     : pixel clock, asynchronous active-high reset
//   i_load       : load i_load_val (wins over a step in the same cycle)
//   i_load_val   : value to load
//   i_step       : frame_end pulse; decrements, holding at zero
//   o_done       : step arriving while the count is already zero
// Loading N therefore yields done on the (N+1)-th step after the load.
// -----------------------------------------------------------------------------
module frame_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_step,
  output logic         o_done
);

  logic [W-1:0] r_count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_step && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_done = i_step && (r_count == '0);

endmodule

// File: rtl/collision_judge.sv
// -----------------------------------------------------------------------------
// collision_judge
// Per-pixel collision detector and life manager for the player plane.
// Counts pixels where the player plane overlaps an enemy plane or enemy bullet
// during active video, decides at most one hit per frame at frame_end, and
// sequences PLAY -> BOOM -> RESPAWN -> PLAY (or OVER when no lives remain).
//   clk, rst         : pixel clock, asynchronous active-high reset
//   io_bus (slave)   : video_on, frame_end, plane_en, enemy_en, ebullet_en,
//                      myplane_exist, restart in;
//                      boom, hit_pulse, lives, invincible, game_over out
// All outputs are registered; boom is a steady level for the renderer's
// explosion counter.
// -----------------------------------------------------------------------------
module collision_judge
  import game_pkg::*;
#(
  parameter int LIVES_INIT  = LIVES_INIT_DEF,
  parameter int LIVES_W     = 2,
  parameter int MIN_OVERLAP = MIN_OVERLAP_DEF,
  parameter int OVL_W       = 12,
  parameter int BOOM_FRAMES = BOOM_FRAMES_DEF,
  parameter int INV_FRAMES  = INV_FRAMES_DEF,
  parameter int FRM_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  collision_judge_if.slave   io_bus
);

  judge_state_t       r_state;
  logic [LIVES_W-1:0] r_lives;
  logic [OVL_W-1:0]   r_ovl_cnt;
  logic               r_boom;
  logic               r_hit_pulse;
  logic               r_invincible;
  logic               r_game_over;

  judge_state_t       w_state_nxt;
  logic [LIVES_W-1:0] w_lives_nxt;
  logic [OVL_W-1:0]   w_ovl_cnt_nxt;
  logic               w_boom_nxt;
  logic               w_hit_nxt;
  logic               w_inv_nxt;
  logic               w_over_nxt;

  logic               w_overlap;
  logic [OVL_W-1:0]   w_ovl_total;
  logic               w_hit_cond;
  logic               w_tmr_load;
  logic [FRM_W-1:0]   w_tmr_val;
  logic               w_tmr_done;

  // ---------------------------------------------------------------------------
  // Overlap counting. w_ovl_total already includes the current pixel, so an
  // overlap on the frame_end cycle itself is judged with the closing frame.
  // ---------------------------------------------------------------------------
  assign w_overlap   = io_bus.video_on && io_bus.plane_en &&
                       (io_bus.enemy_en || io_bus.ebullet_en);
  assign w_ovl_total = (w_overlap && (r_ovl_cnt != '1)) ? r_ovl_cnt + OVL_W'(1)
                                                        : r_ovl_cnt;
  assign w_ovl_cnt_nxt = (io_bus.restart || io_bus.frame_end) ? '0 : w_ovl_total;

  assign w_hit_cond = io_bus.frame_end && io_bus.myplane_exist &&
                      (w_ovl_total >= OVL_W'(MIN_OVERLAP));

  frame_timer #(
    .W (FRM_W)
  ) u_frame_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_step     (io_bus.frame_end),
    .o_done     (w_tmr_done)
  );

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic. Every state transition reloads the frame
  // timer so the entry frame_end never also counts as a step.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that left
    // one unassigned would infer a latch.
    w_state_nxt = r_state;
    w_lives_nxt = r_lives;
    w_boom_nxt  = r_boom;
    w_hit_nxt   = 1'b0;
    w_inv_nxt   = r_invincible;
    w_over_nxt  = r_game_over;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;

    if (io_bus.restart) begin
      // Restart overrides any hit or timer decision in the same cycle.
      w_state_nxt = ST_PLAY;
      w_lives_nxt = LIVES_W'(LIVES_INIT);
      w_boom_nxt  = 1'b0;
      w_inv_nxt   = 1'b0;
      w_over_nxt  = 1'b0;
      w_tmr_load  = 1'b1;
    end else begin
      unique case (r_state)
        ST_PLAY: begin
          if (w_hit_cond) begin
            w_hit_nxt   = 1'b1;
            w_boom_nxt  = 1'b1;
            w_state_nxt = ST_BOOM;
            w_tmr_load  = 1'b1;
            w_tmr_val   = FRM_W'(BOOM_FRAMES - 1);
            if (r_lives != '0) begin
              w_lives_nxt = r_lives - LIVES_W'(1);
            end
          end
        end
        ST_BOOM: begin
          w_boom_nxt = 1'b1;
          if (w_tmr_done) begin
            w_tmr_load = 1'b1;
            if (r_lives == '0) begin
              w_state_nxt = ST_OVER;
              w_over_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_RESPAWN;
              w_boom_nxt  = 1'b0;
              w_inv_nxt   = 1'b1;
              w_tmr_val   = FRM_W'(INV_FRAMES - 1);
            end
          end
        end
        ST_RESPAWN: begin
          // Collisions are ignored during the grace period.
          if (w_tmr_done) begin
            w_state_nxt = ST_PLAY;
            w_inv_nxt   = 1'b0;
            w_tmr_load  = 1'b1;
          end
        end
        ST_OVER: begin
          w_boom_nxt = 1'b1;
          w_over_nxt = 1'b1;
        end
        default: begin
          w_state_nxt = ST_PLAY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_PLAY;
      r_lives      <= LIVES_W'(LIVES_INIT);
      r_ovl_cnt    <= '0;
      r_boom       <= 1'b0;
      r_hit_pulse  <= 1'b0;
      r_invincible <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lives      <= w_lives_nxt;
      r_ovl_cnt    <= w_ovl_cnt_nxt;
      r_boom       <= w_boom_nxt;
      r_hit_pulse  <= w_hit_nxt;
      r_invincible <= w_inv_nxt;
      r_game_over  <= w_over_nxt;
    end
  end

  assign io_bus.boom       = r_boom;
  assign io_bus.hit_pulse  = r_hit_pulse;
  assign io_bus.lives      = r_lives;
  assign io_bus.invincible = r_invincible;
  assign io_bus.game_over  = r_game_over;

endmodule

// File: doc/collision_judge.md
Name: collision_judge

Overview:
- Per-pixel collision detector and life manager for the player plane, one stage upstream of the plane renderer.
- Samples the renderers' per-pixel enable outputs during active video: player plane, enemy planes and enemy bullets.
- Accumulates overlapping pixels over each frame and decides a hit at frame end.
- Drives the level-sensitive boom input of the plane renderer; tracks lives, post-respawn invincibility and game-over.

Parameters:
- LIVES_INIT, 3: lives loaded at reset and on restart.
- LIVES_W, 2: width of the lives counter.
- MIN_OVERLAP, 4: overlapping pixels in one frame needed to register a hit.
- OVL_W, 12: width of the overlap pixel counter; saturates.
- BOOM_FRAMES, 120: frames boom is held before respawn or game-over is decided.
- INV_FRAMES, 90: frames of invincibility after respawn.
- FRM_W, 8: width of the frame timer; must hold max(BOOM_FRAMES, INV_FRAMES).

Ports:
- clk  in  1  pixel-domain clock, same as the renderers.
- rst  in  1  asynchronous, active-high reset.
- video_on  in  1  active display area.
- frame_end  in  1  one-cycle pulse, once per frame, in vertical blanking.
- plane_en  in  1  player plane pixel opaque at the current x,y.
- enemy_en  in  1  any enemy plane pixel opaque at the current x,y.
- ebullet_en  in  1  any enemy bullet pixel opaque at the current x,y.
- myplane_exist  in  1  plane renderer status (1 = intact); observed only in the PLAY hit check.
- restart  in  1  one-cycle pulse from the game controller.
- boom  out  1  to the plane renderer; 1 = exploding or dead.
- hit_pulse  out  1  one-cycle pulse when a hit is registered.
- lives  out  LIVES_W  remaining lives.
- invincible  out  1  1 during the post-respawn grace period.
- game_over  out  1  1 in the OVER state.

Behaviour:
- Reset (async): state=PLAY, lives=LIVES_INIT, overlap count=0, frame timer=0; boom, hit_pulse, invincible and game_over all 0.
- All outputs are registered.
- Overlap counting:
  - overlap = video_on & plane_en & (enemy_en | ebullet_en).
  - The count increments on overlap and saturates at 2^OVL_W-1.
  - It clears on the cycle after frame_end.
  - An overlap coinciding with frame_end counts toward the closing frame.
  - Counting runs in every state; it is consumed only in PLAY.
- frame_timer: loaded with N on state entry; decrements on each frame_end; done = (timer==0 and frame_end). A first decrement on the entry cycle is not allowed.
- PLAY:
  - Condition: frame_end with count >= MIN_OVERLAP and myplane_exist=1.
  - Action: hit_pulse=1 for 1 cycle, lives = lives-1, boom=1 on the next cycle, go to BOOM.
  - Lives never underflow; decrement only if lives>0.
- BOOM:
  - boom stays 1 throughout; the timer is loaded with BOOM_FRAMES-1, giving exactly BOOM_FRAMES frame_end pulses.
  - On done with lives==0: go to OVER.
  - On done with lives>0: boom=0, invincible=1, timer=INV_FRAMES-1, go to RESPAWN.
- RESPAWN:
  - Hits are ignored (count still clears each frame).
  - On done: invincible=0, go to PLAY.
- OVER:
  - boom=1 and game_over=1, held indefinitely.
- restart:
  - Accepted in any state and takes priority over every other event that cycle, including a hit decision.
  - Next cycle: state=PLAY, lives=LIVES_INIT, boom=0, invincible=0, game_over=0, count=0, timer=0.
- rst asserted mid-explosion returns immediately to reset values; boom drops asynchronously.
- A hit and frame_end in the same frame register at most one hit: one decision per frame_end.
- boom is level-held for the whole BOOM period, since the renderer needs a steady boom to run its explosion counter.

Decomposition:
- Shared package game_pkg holds:
  - state enum: PLAY, BOOM, RESPAWN, OVER;
  - defaults for LIVES_INIT, BOOM_FRAMES, INV_FRAMES, MIN_OVERLAP;
  - the 12-bit white transparency colour constant, shared with the renderers.
- One sub-module, frame_timer: loadable down-counter stepped by frame_end, output done. Reused later for enemy spawn pacing.
- FSM, overlap counter and lives logic stay in collision_judge.

Test Plan:
- Reset with no overlap, then 5 frame_end pulses: boom=0, lives=3, hit_pulse never asserted.
- 3 overlapping pixels in one frame: no hit. 4 pixels (enemy_en): hit_pulse 1 cycle after frame_end, lives=2, boom=1 for 120 frames, then boom=0 and invincible=1 for 90 frames.
- Overlap of 50 pixels every frame during RESPAWN: lives stays 2. First frame after RESPAWN→PLAY: hit registered, lives=1.
- Three hits from lives=3: after the third BOOM period, game_over=1, boom=1, lives=0; further overlaps give no hit_pulse and no underflow.
- restart pulsed in OVER and mid-BOOM: next cycle lives=3, boom=0, game_over=0, state PLAY. restart coinciding with a hit frame_end: no decrement.
- rst asserted mid-BOOM: boom=0 immediately. Overlap pixel coincident with frame_end is counted into the closing frame (3 pixels + 1 on frame_end → hit).
